// File: rtl/os_rx_sequencer_pkg.sv
// rtl/os_rx_sequencer_pkg.sv - shared encodings for the RX ordered-set sequencer
package os_rx_sequencer_pkg;

    // Decoded ordered-set type as reported by the RX decoder
    typedef enum logic [1:0] {
        OS_NONE = 2'd0,
        OS_TS1  = 2'd1,
        OS_TS2  = 2'd2,
        OS_SKP  = 2'd3
    } os_type_e;

    // Sequencer FSM state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARM     = 3'd1;
    localparam logic [2:0] ST_COUNT   = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    // Ordered-set identifier symbols (8b/10b comma and gen3 identifiers)
    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_TS1 = 8'h1E;
    localparam logic [7:0] SYM_TS2 = 8'h2D;
    localparam logic [7:0] SYM_SKP = 8'hAA;

    // True for the two training-set types that can be counted
    function automatic logic is_ts_type(input logic [1:0] os_type);
        return (os_type == OS_TS1) || (os_type == OS_TS2);
    endfunction

endpackage

// File: rtl/os_ts_match_counter.sv
// rtl/os_ts_match_counter.sv - consecutive TS1/TS2 compare-and-count datapath
module os_ts_match_counter
    import os_rx_sequencer_pkg::*;
#(
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 event_i,
    input  logic [1:0]           os_type_i,
    input  logic [1:0]           target_type_i,
    input  logic [7:0]           link_i,
    input  logic [7:0]           lane_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic [CNT_WIDTH-1:0] count_next_o,
    output logic                 hit_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ref_valid_q, ref_valid_d;
    logic [7:0]           ref_link_q, ref_link_d;
    logic [7:0]           ref_lane_q, ref_lane_d;
    logic                 is_target;
    logic                 same_ref;

    assign is_target = is_ts_type(os_type_i) && (os_type_i == target_type_i);
    // With no reference captured yet, any target set extends the run
    assign same_ref  = !ref_valid_q || ((link_i == ref_link_q) && (lane_i == ref_lane_q));

    // Next count and reference: extend, restart at 1, or break the run; SKP is transparent
    always_comb begin
        count_d     = count_q;
        ref_valid_d = ref_valid_q;
        ref_link_d  = ref_link_q;
        ref_lane_d  = ref_lane_q;
        hit_o       = 1'b0;
        if (clear_i) begin
            count_d     = '0;
            ref_valid_d = 1'b0;
        end else if (event_i) begin
            if (is_target) begin
                hit_o       = 1'b1;
                ref_valid_d = 1'b1;
                ref_link_d  = link_i;
                ref_lane_d  = lane_i;
                if (!same_ref) begin
                    count_d = CNT_ONE;
                end else if (count_q != CNT_MAX) begin
                    count_d = count_q + 1'b1;
                end
            end else if (os_type_i != OS_SKP) begin
                count_d     = '0;
                ref_valid_d = 1'b0;
            end
        end
    end

    // Count and reference registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            ref_valid_q <= 1'b0;
            ref_link_q  <= 8'h00;
            ref_lane_q  <= 8'h00;
        end else begin
            count_q     <= count_d;
            ref_valid_q <= ref_valid_d;
            ref_link_q  <= ref_link_d;
            ref_lane_q  <= ref_lane_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/os_rx_sequencer.sv
// rtl/os_rx_sequencer.sv - RX ordered-set sequencer controlling the decoder for the LTSSM
module os_rx_sequencer
    import os_rx_sequencer_pkg::*;
#(
    parameter int                     TIMER_WIDTH    = 24,
    parameter logic [TIMER_WIDTH-1:0] TIMEOUT_CYCLES = 24'd24000,
    parameter int                     CNT_WIDTH      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           targetType,
    input  logic [CNT_WIDTH-1:0] targetCount,
    input  logic                 osValid,
    input  logic [1:0]           osType,
    input  logic [7:0]           osLinkNum,
    input  logic [7:0]           osLaneNum,
    output logic                 decoderEnable,
    output logic                 busy,
    output logic                 done,
    output logic                 timeoutFlag,
    output logic [7:0]           matchedLinkNum,
    output logic [7:0]           matchedLaneNum,
    output logic [CNT_WIDTH-1:0] tsCount
);

    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMEOUT_CYCLES - 1'b1;
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX  = {TIMER_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]             state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [1:0]             target_type_q, target_type_d;
    logic [CNT_WIDTH-1:0]   target_cnt_q, target_cnt_d;
    logic [7:0]             matched_link_q, matched_link_d;
    logic [7:0]             matched_lane_q, matched_lane_d;

    logic                   in_idle, in_arm, in_count;
    logic                   start_accept;
    logic                   cnt_clear;
    logic                   cnt_event;
    logic                   cnt_hit;
    logic [CNT_WIDTH-1:0]   cnt_value;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic                   complete;
    logic                   timer_expired;

    assign in_idle  = (state_q == ST_IDLE);
    assign in_arm   = (state_q == ST_ARM);
    assign in_count = (state_q == ST_COUNT);

    // abort outranks everything, so a simultaneous start is dropped
    assign start_accept  = in_idle && start && !abort;
    assign cnt_clear     = abort || start_accept;
    // Decoder output is consumed only in COUNT; the ARM cycle flushes stale events
    assign cnt_event     = in_count && osValid && !abort;
    assign complete      = cnt_event && cnt_hit && (cnt_next == target_cnt_q);
    assign timer_expired = in_count && (timer_q == TIMER_LAST);

    os_ts_match_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_match_counter (
        .clk           (clk),
        .rst_n         (reset),
        .clear_i       (cnt_clear),
        .event_i       (cnt_event),
        .os_type_i     (osType),
        .target_type_i (target_type_q),
        .link_i        (osLinkNum),
        .lane_i        (osLaneNum),
        .count_o       (cnt_value),
        .count_next_o  (cnt_next),
        .hit_o         (cnt_hit)
    );

    // FSM next state; completion is checked before timeout so it wins a tie
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_ARM;
                ST_ARM:   state_d = ST_COUNT;
                ST_COUNT: begin
                    if (complete) begin
                        state_d = ST_DONE;
                    end else if (timer_expired) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Timer, latched target and matched link/lane next values
    always_comb begin
        timer_d        = timer_q;
        target_type_d  = target_type_q;
        target_cnt_d   = target_cnt_q;
        matched_link_d = matched_link_q;
        matched_lane_d = matched_lane_q;
        if (start_accept || in_arm) begin
            timer_d = '0;
        end else if (in_count && (timer_q != TIMER_MAX)) begin
            timer_d = timer_q + 1'b1;
        end
        if (start_accept) begin
            target_type_d = targetType;
            target_cnt_d  = (targetCount == '0) ? CNT_ONE : targetCount;
        end
        if (complete) begin
            matched_link_d = osLinkNum;
            matched_lane_d = osLaneNum;
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            target_type_q  <= 2'd0;
            target_cnt_q   <= '0;
            matched_link_q <= 8'h00;
            matched_lane_q <= 8'h00;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            target_type_q  <= target_type_d;
            target_cnt_q   <= target_cnt_d;
            matched_link_q <= matched_link_d;
            matched_lane_q <= matched_lane_d;
        end
    end

    // Outputs decode straight from the state register so reset clears them at once
    assign decoderEnable  = in_arm || in_count;
    assign busy           = in_arm || in_count;
    assign done           = (state_q == ST_DONE);
    assign timeoutFlag    = (state_q == ST_TIMEOUT);
    assign matchedLinkNum = matched_link_q;
    assign matchedLaneNum = matched_lane_q;
    assign tsCount        = cnt_value;

endmodule
